pixel_frame_writer: RTL and testbench
=====================================

Name: pixel_frame_writer

Overview:
- Write-side producer for the lower half-matrix pixel RAM; drives its 32-bit column write port (write enable, 10-bit word address, 32-bit data).
- Accepts a valid/ready stream of 4-bit pixels and packs 8 pixels per 32-bit word.
- Writes packed words to sequential word addresses and wraps at frame end.
- Also provides a fill command that writes one colour to the whole frame.

Parameters:
- ADDR_W, 10, word-address width; matches the RAM write address.
- FRAME_WORDS, 1024, words per frame; the last word address is FRAME_WORDS-1. Legal range 1..2**ADDR_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- pix_valid  in  1  pixel stream valid.
- pix_ready  out  1  pixel stream ready.
- pix_data  in  4  pixel colour.
- pix_sof  in  1  marks the first pixel of a frame; sampled only on accept.
- clear_req  in  1  one-cycle fill request.
- clear_color  in  4  fill colour; sampled when clear_req is taken.
- clear_done  out  1  one-cycle pulse when the fill completes.
- frame_done  out  1  one-cycle pulse with the write of word FRAME_WORDS-1 in PACK state.
- we_lower  out  1  RAM write strobe.
- wraddr_col_lower  out  ADDR_W  RAM word address.
- din_col_lower  out  32  RAM write data.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=PACK, nib_cnt=0, word_addr=0; we_lower, clear_done and frame_done = 0; wraddr_col_lower and din_col_lower = 0.
- Registers: all outputs except pix_ready are registered.
- pix_ready: combinational, equal to (state==PACK) && !clear_req.
- Accept: an accept occurs when pix_valid && pix_ready. On accept, pix_data goes into nibble nib_cnt, bits [4*nib_cnt+3 : 4*nib_cnt]. Pixel address p therefore maps to word p>>3, nibble p[2:0], matching the RAM's 4-bit read port.
- pix_sof on accept: nib_cnt and word_addr restart at 0 before this pixel is stored. Any partial word is discarded and never written.
- Word write: the accept that fills nibble 7 causes, on the next cycle, we_lower=1 for exactly one cycle, with wraddr_col_lower=word_addr and din_col_lower=the packed word.
- Address advance: word_addr increments after each write. At FRAME_WORDS-1 it wraps to 0, and frame_done pulses in the same cycle as that write.
- Throughput: one pixel per cycle sustained. No stalls are caused by writes.
- Fill command: clear_req seen in PACK enters CLEAR.
  - The partial word is discarded; nib_cnt=0.
  - clear_color is latched.
  - Writes {8{clear_color}} to addresses 0..FRAME_WORDS-1, one per cycle. The first write appears the cycle after clear_req.
  - After the last write: clear_done pulses, state returns to PACK with word_addr=0.
  - frame_done is not pulsed during CLEAR.
- Simultaneous events:
  - clear_req wins over a pixel; that pixel is not accepted.
  - clear_req while in CLEAR is ignored.
  - A write pending from the nibble-7 accept in the same cycle as clear_req is still issued. CLEAR writes start one cycle later.
- Reset mid-operation: rst during PACK or CLEAR aborts immediately. Partially written RAM contents are left as they are, and no done pulses are generated.
- Degenerate size: FRAME_WORDS=1 means every write pulses frame_done; CLEAR lasts 1 cycle.

Optional Feature:
- Macro: PIXEL_FRAME_WRITER_STATUS_EN.
- When defined, adds output port short_frames (out, 8 bits, reset 0).
  - Increments, saturating at 255, on each accepted pix_sof where nib_cnt!=0 or word_addr!=0, i.e. a frame was truncated.
  - An sof at nib_cnt=0, word_addr=0 does not count.
- When undefined: the port is absent, with no other behavioural change.

Decomposition:
- Package led_matrix_pkg holds:
  - constants PIX_W=4, PIX_PER_WORD=8, WORD_W=32;
  - typedef pix_t (logic [3:0]);
  - typedef wr_state_t enum {PACK, CLEAR}.
- One natural sub-module, pix_word_packer: holds nib_cnt and the shift/insert register, and outputs word_full and the packed word. The top level owns the FSM, the address counter and the output registers.

Test Plan:
- Pack order: after reset, send pixels 1,2,...,8 (no sof) -> one write at address 0 with data 32'h87654321; we_lower high exactly 1 cycle, 1 cycle after the 8th accept.
- Frame wrap: FRAME_WORDS=4; stream 32 pixels of 4'h4 -> writes to 0,1,2,3 of 32'h44444444; frame_done coincides with the address-3 write; the next 8 pixels write address 0.
- Truncated frame: send 5 pixels, then pix_sof with 8 more pixels of 4'h2 -> a single write of 32'h22222222 at address 0. With STATUS_EN, short_frames=1.
- Fill: FRAME_WORDS=4; clear_req with clear_color=4'h1 and pix_valid held high -> pix_ready=0, writes 32'h11111111 to 0..3 on consecutive cycles, clear_done one cycle after the last write, then packing resumes at address 0.
- Collision: the 8th pixel is accepted one cycle before clear_req -> the packed word is written first, then the fill writes start; the pixel offered in the clear_req cycle is not accepted.
- Reset: assert rst asynchronously during the fill after 2 writes -> we_lower drops immediately, clear_done never pulses, all outputs read 0.

Source files
------------

// File: rtl/pixel_frame_writer_pkg.sv
// Shared types and constants for the pixel frame writer (package led_matrix_pkg).
package led_matrix_pkg;

  localparam int PIX_W        = 4;
  localparam int PIX_PER_WORD = 8;
  localparam int WORD_W       = 32;

  typedef logic [PIX_W-1:0] pix_t;

  typedef enum logic {
    PACK  = 1'b0,
    CLEAR = 1'b1
  } wr_state_t;

  function automatic logic [WORD_W-1:0] fill_word(input pix_t color);
    return {PIX_PER_WORD{color}};
  endfunction

endpackage

// File: rtl/pix_word_packer.sv
// Packs accepted 4-bit pixels into a 32-bit word, pixel n landing in nibble n.
module pix_word_packer
  import led_matrix_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              accept,
  input  logic              sof,
  input  logic              flush,
  input  pix_t              pix,
  output logic [2:0]        nib_cnt,
  output logic              word_full,
  output logic [WORD_W-1:0] word
);

  logic [2:0]        nib_cnt_q, nib_cnt_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [2:0]        nib_idx;
  logic [WORD_W-1:0] base;

  always_comb begin
    // A start-of-frame pixel restarts the word, dropping any partial content.
    nib_idx = sof ? 3'd0 : nib_cnt_q;
    base    = sof ? '0 : word_q;
    word    = base;
    for (int i = 0; i < PIX_PER_WORD; i++) begin
      if (3'(i) == nib_idx) word[i*PIX_W +: PIX_W] = pix;
    end
    word_full = accept && (nib_idx == 3'd7);

    nib_cnt_d = nib_cnt_q;
    word_d    = word_q;
    if (flush) begin
      nib_cnt_d = 3'd0;
      word_d    = '0;
    end else if (accept) begin
      nib_cnt_d = nib_idx + 3'd1;
      word_d    = word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nib_cnt_q <= 3'd0;
      word_q    <= '0;
    end else begin
      nib_cnt_q <= nib_cnt_d;
      word_q    <= word_d;
    end
  end

  assign nib_cnt = nib_cnt_q;

endmodule

// File: rtl/pixel_frame_writer.sv
// Pixel stream to lower-half RAM column writer with whole-frame fill command.
// Optional macro PIXEL_FRAME_WRITER_STATUS_EN adds the short_frames counter port.
//
// state | meaning
// PACK  | packing accepted pixels, one word write per 8 pixels
// CLEAR | writing the latched fill colour to every frame word
module pixel_frame_writer
  import led_matrix_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int FRAME_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  pix_t              pix_data,
  input  logic              pix_sof,
  input  logic              clear_req,
  input  pix_t              clear_color,
  output logic              clear_done,
  output logic              frame_done,
`ifdef PIXEL_FRAME_WRITER_STATUS_EN
  output logic [7:0]        short_frames,
`endif
  output logic              we_lower,
  output logic [ADDR_W-1:0] wraddr_col_lower,
  output logic [WORD_W-1:0] din_col_lower
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);
  localparam logic [ADDR_W-1:0] FILL_NEXT = (FRAME_WORDS == 1) ? '0 : ADDR_W'(1);

  wr_state_t         state_q, state_d;
  logic [ADDR_W-1:0] word_addr_q, word_addr_d;
  pix_t              color_q, color_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] wraddr_q, wraddr_d;
  logic [WORD_W-1:0] din_q, din_d;
  logic              clear_done_q, clear_done_d;
  logic              frame_done_q, frame_done_d;

  logic              accept;
  logic              flush;
  logic [ADDR_W-1:0] eff_addr;
  logic [2:0]        nib_cnt;
  logic              word_full;
  logic [WORD_W-1:0] packed_word;

  pix_word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .accept    (accept),
    .sof       (pix_sof),
    .flush     (flush),
    .pix       (pix_data),
    .nib_cnt   (nib_cnt),
    .word_full (word_full),
    .word      (packed_word)
  );

  always_comb begin
    pix_ready = (state_q == PACK) && !clear_req;
    accept    = pix_valid && pix_ready;
    flush     = (state_q == PACK) && clear_req;
    eff_addr  = (accept && pix_sof) ? '0 : word_addr_q;

    state_d      = state_q;
    word_addr_d  = word_addr_q;
    color_d      = color_q;
    we_d         = 1'b0;
    wraddr_d     = wraddr_q;
    din_d        = din_q;
    clear_done_d = 1'b0;
    frame_done_d = 1'b0;

    case (state_q)
      PACK: begin
        if (clear_req) begin
          // First fill write is issued right away so it lands the next cycle.
          state_d     = CLEAR;
          color_d     = clear_color;
          we_d        = 1'b1;
          wraddr_d    = '0;
          din_d       = fill_word(clear_color);
          word_addr_d = FILL_NEXT;
        end else begin
          word_addr_d = eff_addr;
          if (word_full) begin
            we_d         = 1'b1;
            wraddr_d     = eff_addr;
            din_d        = packed_word;
            frame_done_d = (eff_addr == LAST_ADDR);
            word_addr_d  = (eff_addr == LAST_ADDR) ? '0 : eff_addr + 1'b1;
          end
        end
      end
      CLEAR: begin
        // The write currently on the port is the last one once it shows LAST_ADDR.
        if (wraddr_q == LAST_ADDR) begin
          state_d      = PACK;
          clear_done_d = 1'b1;
          word_addr_d  = '0;
        end else begin
          we_d        = 1'b1;
          wraddr_d    = word_addr_q;
          din_d       = fill_word(color_q);
          word_addr_d = word_addr_q + 1'b1;
        end
      end
      default: state_d = PACK;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= PACK;
      word_addr_q  <= '0;
      color_q      <= '0;
      we_q         <= 1'b0;
      wraddr_q     <= '0;
      din_q        <= '0;
      clear_done_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_addr_q  <= word_addr_d;
      color_q      <= color_d;
      we_q         <= we_d;
      wraddr_q     <= wraddr_d;
      din_q        <= din_d;
      clear_done_q <= clear_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign we_lower         = we_q;
  assign wraddr_col_lower = wraddr_q;
  assign din_col_lower    = din_q;
  assign clear_done       = clear_done_q;
  assign frame_done       = frame_done_q;

`ifdef PIXEL_FRAME_WRITER_STATUS_EN
  logic [7:0] short_frames_q, short_frames_d;

  always_comb begin
    short_frames_d = short_frames_q;
    if (accept && pix_sof && ((nib_cnt != 3'd0) || (word_addr_q != '0)) &&
        (short_frames_q != 8'hFF)) begin
      short_frames_d = short_frames_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) short_frames_q <= 8'd0;
    else     short_frames_q <= short_frames_d;
  end

  assign short_frames = short_frames_q;
`else
  logic unused_nib_cnt;
  assign unused_nib_cnt = ^nib_cnt;
`endif

endmodule

// File: tb/tb_pixel_frame_writer.sv
// Directed bench for pixel_frame_writer with a 4-word frame; short_frames checked
// when PIXEL_FRAME_WRITER_STATUS_EN is defined.
module tb_pixel_frame_writer;
  import led_matrix_pkg::*;

  localparam int ADDR_W = 10;
  localparam int FW     = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              pix_valid;
  logic              pix_ready;
  pix_t              pix_data;
  logic              pix_sof;
  logic              clear_req;
  pix_t              clear_color;
  logic              clear_done;
  logic              frame_done;
  logic              we_lower;
  logic [ADDR_W-1:0] wraddr_col_lower;
  logic [31:0]       din_col_lower;
`ifdef PIXEL_FRAME_WRITER_STATUS_EN
  logic [7:0]        short_frames;
`endif

  int checks = 0;
  int errors = 0;

  pixel_frame_writer #(.ADDR_W(ADDR_W), .FRAME_WORDS(FW)) dut (
    .clk              (clk),
    .rst              (rst),
    .pix_valid        (pix_valid),
    .pix_ready        (pix_ready),
    .pix_data         (pix_data),
    .pix_sof          (pix_sof),
    .clear_req        (clear_req),
    .clear_color      (clear_color),
    .clear_done       (clear_done),
    .frame_done       (frame_done),
`ifdef PIXEL_FRAME_WRITER_STATUS_EN
    .short_frames     (short_frames),
`endif
    .we_lower         (we_lower),
    .wraddr_col_lower (wraddr_col_lower),
    .din_col_lower    (din_col_lower)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_write(input string tag, input logic [31:0] addr,
                             input logic [31:0] data, input logic fd);
    check({tag, "_we"}, 32'(we_lower), 32'd1);
    check({tag, "_addr"}, 32'(wraddr_col_lower), addr);
    check({tag, "_data"}, din_col_lower, data);
    check({tag, "_frame_done"}, 32'(frame_done), 32'(fd));
  endtask

  task automatic send(input pix_t p, input logic sof);
    pix_valid = 1'b1;
    pix_data  = p;
    pix_sof   = sof;
    step();
    pix_sof   = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    pix_valid   = 1'b0;
    pix_data    = '0;
    pix_sof     = 1'b0;
    clear_req   = 1'b0;
    clear_color = '0;
    repeat (3) step();

    check("rst_we", 32'(we_lower), 32'd0);
    check("rst_addr", 32'(wraddr_col_lower), 32'd0);
    check("rst_data", din_col_lower, 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_clear_done", 32'(clear_done), 32'd0);
    check("rst_ready", 32'(pix_ready), 32'd1);
`ifdef PIXEL_FRAME_WRITER_STATUS_EN
    check("rst_short_frames", 32'(short_frames), 32'd0);
`endif
    rst = 1'b0;
    step();

    // Pack order: pixels 1..8 land as 0x87654321 at address 0.
    for (int i = 1; i <= 8; i++) begin
      send(pix_t'(i), 1'b0);
      if (i < 8) check("pack_no_early_we", 32'(we_lower), 32'd0);
    end
    check_write("pack", 32'd0, 32'h87654321, 1'b0);
    pix_valid = 1'b0;
    step();
    check("pack_we_one_cycle", 32'(we_lower), 32'd0);

    // Frame wrap: sof restarts at address 0, 4 words, frame_done on address 3.
    for (int j = 0; j < 32; j++) begin
      send(4'h4, j == 0);
      if (j % 8 == 7) check_write("wrap", 32'(j / 8), 32'h44444444, j == 31);
      else            check("wrap_idle_we", 32'(we_lower), 32'd0);
    end
    for (int j = 0; j < 8; j++) send(4'h5, 1'b0);
    check_write("wrap_again", 32'd0, 32'h55555555, 1'b0);
`ifdef PIXEL_FRAME_WRITER_STATUS_EN
    check("short_frames_wrap_sof", 32'(short_frames), 32'd1);
`endif

    // Truncated frame: 5 pixels discarded by a following sof.
    for (int j = 0; j < 5; j++) send(4'h7, 1'b0);
    check("trunc_no_we", 32'(we_lower), 32'd0);
    for (int j = 0; j < 8; j++) send(4'h2, j == 0);
    check_write("trunc", 32'd0, 32'h22222222, 1'b0);
    pix_valid = 1'b0;
    step();
    check("trunc_single_write", 32'(we_lower), 32'd0);
`ifdef PIXEL_FRAME_WRITER_STATUS_EN
    check("short_frames_trunc", 32'(short_frames), 32'd2);
`endif

    // Fill with colour 1 while pixels are continuously offered.
    pix_valid   = 1'b1;
    pix_data    = 4'h9;
    clear_req   = 1'b1;
    clear_color = 4'h1;
    #1;
    check("fill_ready_on_req", 32'(pix_ready), 32'd0);
    step();
    clear_req   = 1'b0;
    clear_color = 4'h0;
    for (int k = 0; k < FW; k++) begin
      if (k > 0) step();
      check_write("fill", 32'(k), 32'h11111111, 1'b0);
      check("fill_ready", 32'(pix_ready), 32'd0);
      check("fill_no_done", 32'(clear_done), 32'd0);
    end
    step();
    check("fill_done", 32'(clear_done), 32'd1);
    check("fill_done_we", 32'(we_lower), 32'd0);
    check("fill_ready_after", 32'(pix_ready), 32'd1);
    for (int j = 0; j < 8; j++) begin
      send(4'h9, 1'b0);
      if (j == 0) check("fill_done_pulse", 32'(clear_done), 32'd0);
    end
    check_write("fill_resume", 32'd0, 32'h99999999, 1'b0);

    // Collision: word completes one cycle before clear_req.
    for (int j = 0; j < 7; j++) send(4'h3, 1'b0);
    send(4'h5, 1'b0);
    check_write("coll_pack", 32'd1, 32'h53333333, 1'b0);
    pix_data    = 4'hF;
    clear_req   = 1'b1;
    clear_color = 4'hA;
    #1;
    check("coll_ready", 32'(pix_ready), 32'd0);
    step();
    clear_req = 1'b0;
    pix_valid = 1'b0;
    check_write("coll_fill0", 32'd0, 32'hAAAAAAAA, 1'b0);
    repeat (FW - 1) step();
    check_write("coll_fill_last", 32'(FW - 1), 32'hAAAAAAAA, 1'b0);
    step();
    check("coll_done", 32'(clear_done), 32'd1);
    step();

    // Reset during fill after two writes.
    clear_req   = 1'b1;
    clear_color = 4'h2;
    step();
    clear_req = 1'b0;
    step();
    check_write("rstmid_fill1", 32'd1, 32'h22222222, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("rstmid_we", 32'(we_lower), 32'd0);
    check("rstmid_addr", 32'(wraddr_col_lower), 32'd0);
    check("rstmid_data", din_col_lower, 32'd0);
    check("rstmid_clear_done", 32'(clear_done), 32'd0);
`ifdef PIXEL_FRAME_WRITER_STATUS_EN
    check("rstmid_short_frames", 32'(short_frames), 32'd0);
`endif
    step();
    rst = 1'b0;
    for (int j = 0; j < 6; j++) begin
      step();
      check("rstmid_no_done", 32'(clear_done), 32'd0);
      check("rstmid_no_we", 32'(we_lower), 32'd0);
    end
    check("rstmid_ready", 32'(pix_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
